// File: rtl/math_ctrl_pkg.sv
// Shared constants for the a*sqrt(b) math unit controller.
// Covers the register map, CTRL/STATUS bit positions and the FSM state encoding.
package math_ctrl_pkg;

    localparam logic [1:0] ADDR_OPA  = 2'd0;
    localparam logic [1:0] ADDR_OPB  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_RES  = 2'd3;

    // CTRL write bits; STATUS read bits share positions 1..3 with the W1C bits
    localparam int CTRL_GO      = 0;
    localparam int CTRL_DONE    = 1;
    localparam int CTRL_TIMEOUT = 2;
    localparam int CTRL_OVERRUN = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_OVERRUN = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/math_ctrl_timer.sv
// Clearable up-counter for the WAIT phase.
// terminal is high while the count equals TIMEOUT_CYCLES; the counter saturates there.
module math_ctrl_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_reg;

    assign terminal = (count_reg == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !terminal) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/math_unit_ctrl.sv
// Bus-side initiator for the a*sqrt(b) math unit: operand/control registers,
// start/busy handshake FSM, result capture and status flags.
module math_unit_ctrl
    import math_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq_done,
    output logic [7:0]  mu_a,
    output logic [7:0]  mu_b,
    output logic        mu_start,
    input  logic        mu_busy,
    input  logic [15:0] mu_res
);

    state_t      state_reg;
    logic [7:0]  opa_reg;
    logic [7:0]  opb_reg;
    logic [7:0]  op_a_reg;
    logic [7:0]  op_b_reg;
    logic [15:0] result_reg;
    logic        done_reg;
    logic        timeout_reg;
    logic        overrun_reg;
    logic        start_reg;
    logic        irq_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;
    logic        terminal;

    logic ctrl_wr;
    logic go;
    logic unused_wdata;

    assign ctrl_wr      = bus_we && (bus_addr == ADDR_CTRL);
    assign go           = ctrl_wr && bus_wdata[CTRL_GO];
    assign unused_wdata = &{1'b0, bus_wdata[31:8]};

    assign bus_rdata = rdata_reg;
    assign irq_done  = irq_reg;
    assign mu_a      = op_a_reg;
    assign mu_b      = op_b_reg;
    assign mu_start  = start_reg;

    math_ctrl_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (state_reg == S_START),
        .enable  (state_reg == S_WAIT),
        .terminal(terminal)
    );

    always_comb begin
        rdata_next = 32'd0;
        case (bus_addr)
            ADDR_OPA:  rdata_next = {24'd0, opa_reg};
            ADDR_OPB:  rdata_next = {24'd0, opb_reg};
            ADDR_CTRL: begin
                rdata_next[STAT_BUSY]    = (state_reg != S_IDLE);
                rdata_next[STAT_DONE]    = done_reg;
                rdata_next[STAT_TIMEOUT] = timeout_reg;
                rdata_next[STAT_OVERRUN] = overrun_reg;
            end
            default:   rdata_next = {16'd0, result_reg};
        endcase
    end

    // W1C updates come first so any flag set later in this block wins the same cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg   <= S_IDLE;
            opa_reg     <= '0;
            opb_reg     <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            overrun_reg <= 1'b0;
            start_reg   <= 1'b0;
            irq_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            irq_reg <= 1'b0;

            if (bus_we && bus_addr == ADDR_OPA) opa_reg <= bus_wdata[7:0];
            if (bus_we && bus_addr == ADDR_OPB) opb_reg <= bus_wdata[7:0];
            if (ctrl_wr) begin
                if (bus_wdata[CTRL_DONE])    done_reg    <= 1'b0;
                if (bus_wdata[CTRL_TIMEOUT]) timeout_reg <= 1'b0;
                if (bus_wdata[CTRL_OVERRUN]) overrun_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        op_a_reg    <= opa_reg;
                        op_b_reg    <= opb_reg;
                        done_reg    <= 1'b0;
                        timeout_reg <= 1'b0;
                        start_reg   <= 1'b1;
                        state_reg   <= S_START;
                    end
                end
                S_START: begin
                    start_reg <= 1'b0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (!mu_busy) begin
                        result_reg <= mu_res;
                        done_reg   <= 1'b1;
                        irq_reg    <= 1'b1;
                        state_reg  <= S_IDLE;
                    end else if (terminal) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end
                end
                default: begin
                    start_reg <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase

            if (go && state_reg != S_IDLE) overrun_reg <= 1'b1;

            if (bus_re) rdata_reg <= rdata_next;
        end
    end

endmodule

// File: tb/tb_math_unit_ctrl.sv
// Directed bench for math_unit_ctrl with a behavioural a*sqrt(b) unit stub
// (fixed latency, optional stuck-busy mode).
module tb_math_unit_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        irq_done;
    logic [7:0]  mu_a;
    logic [7:0]  mu_b;
    logic        mu_start;
    logic        mu_busy;
    logic [15:0] mu_res;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    math_unit_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq_done (irq_done),
        .mu_a     (mu_a),
        .mu_b     (mu_b),
        .mu_start (mu_start),
        .mu_busy  (mu_busy),
        .mu_res   (mu_res)
    );

    // Math unit stub: busy for 6 cycles after start, result = a * floor(sqrt(b))
    logic        stuck = 1'b0;
    logic [3:0]  stub_cnt;
    logic [15:0] stub_res;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stub_cnt <= 4'd0;
            stub_res <= 16'd0;
        end else if (mu_start && stub_cnt == 4'd0) begin
            stub_cnt <= 4'd6;
            stub_res <= 16'(int'(mu_a) * isqrt(int'(mu_b)));
        end else if (stub_cnt != 4'd0) begin
            stub_cnt <= stub_cnt - 4'd1;
        end
    end

    assign mu_busy = mu_start | (stub_cnt != 4'd0) | stuck;
    assign mu_res  = stub_res;

    // Pulse monitor, sampled on the falling edge
    int  start_cnt = 0;
    int  irq_cnt   = 0;
    int  run_len   = 0;
    int  max_run   = 0;
    logic prev_start = 1'b0;

    always @(negedge clk_in) begin
        if (mu_start) begin
            run_len = run_len + 1;
            if (!prev_start) start_cnt = start_cnt + 1;
        end else begin
            run_len = 0;
        end
        if (run_len > max_run) max_run = run_len;
        if (irq_done) irq_cnt = irq_cnt + 1;
        prev_start = mu_start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_in);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk_in);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_in);
        bus_re = 1'b1; bus_addr = a;
        @(negedge clk_in);
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    // Poll STATUS until busy drops; returns the final status word
    task automatic wait_idle(input string tag, input int budget, output logic [31:0] st);
        logic idle = 1'b0;
        st = 32'hFFFF_FFFF;
        for (int i = 0; i < budget && !idle; i++) begin
            bus_read(2'd2, st);
            idle = !st[0];
        end
        check(tag, {31'd0, idle}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_res);
        logic [31:0] d;
        int s0, i0;
        s0 = start_cnt; i0 = irq_cnt;
        bus_write(2'd0, {24'd0, a});
        bus_write(2'd1, {24'd0, b});
        bus_write(2'd2, 32'd1);
        wait_idle({tag, "_idle"}, 40, d);
        check({tag, "_status"}, d, 32'h2);
        bus_read(2'd3, d);
        check({tag, "_result"}, d, {16'd0, exp_res});
        check({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
        check({tag, "_irqs"}, 32'(irq_cnt - i0), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int s0, i0;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_outs", {15'd0, irq_done, mu_start, mu_a, mu_b}, 32'd0);
        bus_read(2'd2, d);
        check("rst_status", d, 32'd0);
        bus_read(2'd3, d);
        check("rst_result", d, 32'd0);

        // First op with busy visible in STATUS
        s0 = start_cnt; i0 = irq_cnt;
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'h0000_0131);    // truncates to 49
        bus_write(2'd2, 32'd1);
        bus_read(2'd2, d);
        check("op1_busy", d & 32'h1, 32'd1);
        check("op1_operands", {16'd0, mu_a, mu_b}, {16'd0, 8'd5, 8'd49});
        wait_idle("op1_idle", 40, d);
        check("op1_status", d, 32'h2);
        bus_read(2'd3, d);
        check("op1_result", d, 32'h0023);
        check("op1_starts", 32'(start_cnt - s0), 32'd1);
        check("op1_irqs", 32'(irq_cnt - i0), 32'd1);

        run_op("op255", 8'd255, 8'd255, 16'h0EF1);
        run_op("op200", 8'd200, 8'd0, 16'h0000);
        check("start_width", 32'(max_run), 32'd1);

        // GO while active: overrun, shadow-only OPA update, single start
        s0 = start_cnt;
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'd49);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'd9);
        bus_write(2'd2, 32'd1);
        check("ovr_mu_a", {24'd0, mu_a}, 32'd5);
        wait_idle("ovr_idle", 40, d);
        check("ovr_status", d, 32'hA);
        bus_read(2'd3, d);
        check("ovr_result", d, 32'h0023);
        check("ovr_starts", 32'(start_cnt - s0), 32'd1);
        bus_read(2'd0, d);
        check("ovr_shadow", d, 32'd9);
        bus_write(2'd2, 32'hA);
        bus_read(2'd2, d);
        check("w1c_status", d, 32'd0);

        // Stuck busy: timeout, result kept, no irq, recovery
        i0 = irq_cnt;
        stuck = 1'b1;
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd4);
        bus_write(2'd2, 32'd1);
        repeat (40) @(negedge clk_in);
        bus_read(2'd2, d);
        check("tmo_still_busy", d & 32'h1, 32'd1);
        wait_idle("tmo_idle", 60, d);
        check("tmo_status", d, 32'h4);
        bus_read(2'd3, d);
        check("tmo_result", d, 32'h0023);
        check("tmo_irqs", 32'(irq_cnt - i0), 32'd0);
        stuck = 1'b0;
        repeat (8) @(negedge clk_in);
        run_op("after_tmo", 8'd7, 8'd9, 16'h0015);

        // Async reset in the middle of WAIT
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'd49);
        bus_write(2'd2, 32'd1);
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("arst_outs", {15'd0, irq_done, mu_start, mu_a, mu_b}, 32'd0);
        check("arst_rdata", bus_rdata, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        bus_read(2'd2, d);
        check("arst_status", d, 32'd0);
        bus_read(2'd3, d);
        check("arst_result", d, 32'd0);
        run_op("post_rst", 8'd9, 8'd16, 16'h0024);

        // Back-to-back: RESULT read in the irq cycle, GO on the cycle after
        s0 = start_cnt;
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'd49);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'd255);
        bus_write(2'd1, 32'd255);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            seen = irq_done;
        end
        check("b2b_irq_seen", {31'd0, seen}, 32'd1);
        bus_re = 1'b1; bus_addr = 2'd3;
        @(negedge clk_in);
        bus_re = 1'b0;
        bus_we = 1'b1; bus_addr = 2'd2; bus_wdata = 32'd1;
        @(negedge clk_in);
        bus_we = 1'b0;
        check("b2b_first", bus_rdata, 32'h0023);
        wait_idle("b2b_idle", 40, d);
        check("b2b_status", d, 32'h2);
        bus_read(2'd3, d);
        check("b2b_second", d, 32'h0EF1);
        check("b2b_starts", 32'(start_cnt - s0), 32'd2);
        check("final_width", 32'(max_run), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
